// File: rtl/cordic_quad_post_q.sv
// cordic_quad_post_q: CORDIC quadrant post-correction with tag FIFO and registered output stream.
// Optional build macro CORDIC_QPOST_SAT_EN: saturating negation and sat_hit reporting.
`default_nettype none

module cordic_quad_post_q #(
    parameter int W      = 24,
    parameter int QDEPTH = 16,
    parameter int AW     = $clog2(QDEPTH)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          clr,
    input  logic          q_valid,
    output logic          q_ready,
    input  logic [1:0]    q_in,
    input  logic          res_valid,
    output logic          res_ready,
    input  logic [W-1:0]  cos_pre,
    input  logic [W-1:0]  sin_pre,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [W-1:0]  cos,
    output logic [W-1:0]  sin,
    output logic [AW:0]   q_level,
    output logic          err_underflow,
    output logic          sat_hit
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(QDEPTH);

    logic [1:0]    mem_q [QDEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          o_valid_q;
    logic [W-1:0]  cos_q, sin_q;
    logic          err_q;

    logic          empty;
    logic          push;
    logic          accept;
    logic          pop;
    logic [1:0]    tag;
    logic [W-1:0]  neg_c, neg_s;
    logic [W-1:0]  cos_d, sin_d;

    assign empty     = (level_q == '0);
    assign q_ready   = (level_q != FULL_LEVEL);
    assign res_ready = !o_valid_q || o_ready;

    // clr wins over both FIFO ports; an accept on an empty FIFO never moves the pointers
    assign push   = q_valid && q_ready && !clr;
    assign accept = res_valid && res_ready && !clr;
    assign pop    = accept && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= q_in;
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign tag = empty ? 2'b00 : mem_q[rd_ptr_q];

`ifdef CORDIC_QPOST_SAT_EN
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};

    logic c_min, s_min;
    logic sat_d, sat_q;

    assign c_min = (cos_pre == MIN_VAL);
    assign s_min = (sin_pre == MIN_VAL);
    assign neg_c = c_min ? MAX_VAL : -cos_pre;
    assign neg_s = s_min ? MAX_VAL : -sin_pre;

    always_comb begin
        case (tag)
            2'b01:   sat_d = s_min;
            2'b10:   sat_d = c_min || s_min;
            2'b11:   sat_d = c_min;
            default: sat_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)     sat_q <= 1'b0;
        else if (clr)     sat_q <= 1'b0;
        else if (accept)  sat_q <= sat_d;
        else if (o_ready) sat_q <= 1'b0;
    end

    assign sat_hit = sat_q;
`else
    assign neg_c   = -cos_pre;
    assign neg_s   = -sin_pre;
    assign sat_hit = 1'b0;
`endif

    always_comb begin
        case (tag)
            2'b01:   begin cos_d = neg_s;   sin_d = cos_pre; end
            2'b10:   begin cos_d = neg_c;   sin_d = neg_s;   end
            2'b11:   begin cos_d = sin_pre; sin_d = neg_c;   end
            default: begin cos_d = cos_pre; sin_d = sin_pre; end
        endcase
    end

    // Data only loads on accept, so it holds while the consumer stalls
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_valid_q <= 1'b0;
            cos_q     <= '0;
            sin_q     <= '0;
        end else if (clr) begin
            o_valid_q <= 1'b0;
        end else if (accept) begin
            o_valid_q <= 1'b1;
            cos_q     <= cos_d;
            sin_q     <= sin_d;
        end else if (o_ready) begin
            o_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)                err_q <= 1'b0;
        else if (clr)                err_q <= 1'b0;
        else if (accept && empty)    err_q <= 1'b1;
    end

    assign o_valid       = o_valid_q;
    assign cos           = cos_q;
    assign sin           = sin_q;
    assign q_level       = level_q;
    assign err_underflow = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_quad_post_q.sv
// tb_cordic_quad_post_q: directed vectors with a queue scoreboard for cordic_quad_post_q.
`default_nettype none

module tb_cordic_quad_post_q;

    localparam int W      = 24;
    localparam int QDEPTH = 16;
    localparam int AW     = 4;
`ifdef CORDIC_QPOST_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic          clr = 1'b0;
    logic          q_valid = 1'b0;
    logic          q_ready;
    logic [1:0]    q_in = 2'b00;
    logic          res_valid = 1'b0;
    logic          res_ready;
    logic [W-1:0]  cos_pre = '0;
    logic [W-1:0]  sin_pre = '0;
    logic          o_valid;
    logic          o_ready = 1'b1;
    logic [W-1:0]  cos;
    logic [W-1:0]  sin;
    logic [AW:0]   q_level;
    logic          err_underflow;
    logic          sat_hit;

    cordic_quad_post_q #(.W(W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .aresetn(aresetn), .clr(clr),
        .q_valid(q_valid), .q_ready(q_ready), .q_in(q_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .cos_pre(cos_pre), .sin_pre(sin_pre),
        .o_valid(o_valid), .o_ready(o_ready), .cos(cos), .sin(sin),
        .q_level(q_level), .err_underflow(err_underflow), .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        int s;
        bit sat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (aresetn && o_valid && o_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_cos", $signed(cos), e.c);
                check("out_sin", $signed(sin), e.s);
                check("out_sat", sat_hit, e.sat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tag(input logic [1:0] t);
        q_valid = 1'b1;
        q_in    = t;
        tick();
        q_valid = 1'b0;
    endtask

    // Offers one result and waits (bounded) for its handshake; expectation queued on accept
    task automatic send(input int c, input int s, input int ec, input int es, input bit esat);
        logic [31:0] cv, sv;
        bit done;
        cv = c;
        sv = s;
        done = 1'b0;
        res_valid = 1'b1;
        cos_pre   = cv[W-1:0];
        sin_pre   = sv[W-1:0];
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (res_ready) begin
                exp_t e;
                e.c = ec; e.s = es; e.sat = esat;
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 0, 1);
        res_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_level", q_level, 0);
        check("rst_valid", o_valid, 0);
        check("rst_cos", cos, 0);
        check("rst_err", err_underflow, 0);
        check("rst_sat", sat_hit, 0);
        aresetn = 1'b1;
        tick();
        check("rst_qready", q_ready, 1);

        // Tag ordering through all four quadrants
        for (int i = 0; i < 4; i++) push_tag(2'(i));
        check("order_level4", q_level, 4);
        send(100000, 50000, 100000, 50000, 0);
        send(100000, 50000, -50000, 100000, 0);
        send(100000, 50000, -100000, -50000, 0);
        send(100000, 50000, 50000, -100000, 0);
        tick();
        tick();
        check("order_level0", q_level, 0);
        check("order_drained", exp_q.size(), 0);

        // Backpressure with three pending results
        push_tag(2'b00);
        push_tag(2'b01);
        push_tag(2'b10);
        o_ready = 1'b0;
        send(1, 2, 1, 2, 0);
        res_valid = 1'b1;
        cos_pre = 24'd3;
        sin_pre = 24'd4;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_res_ready", res_ready, 0);
            check("bp_hold_cos", $signed(cos), 1);
            check("bp_hold_sin", $signed(sin), 2);
            tick();
        end
        o_ready = 1'b1;
        send(3, 4, -4, 3, 0);
        send(5, 6, -5, -6, 0);
        tick();
        tick();
        check("bp_outputs", n_out, 7);
        check("bp_drained", exp_q.size(), 0);

        // FIFO full
        q_valid = 1'b1;
        q_in = 2'b11;
        for (int i = 0; i < QDEPTH; i++) tick();
        check("full_level", q_level, 16);
        check("full_qready", q_ready, 0);
        tick();
        q_valid = 1'b0;
        check("full_17th_ignored", q_level, 16);
        send(1, 2, 2, -1, 0);
        check("full_pop_level", q_level, 15);
        q_valid = 1'b1;
        send(3, 4, 4, -3, 0);
        q_valid = 1'b0;
        check("pushpop_level", q_level, 15);
        push_tag(2'b11);
        check("refull_level", q_level, 16);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_level", q_level, 0);
        check("clr_qready", q_ready, 1);

        // Underflow, then simultaneous push and underflow pop
        send(7, 3, 7, 3, 0);
        check("uf_err", err_underflow, 1);
        check("uf_level", q_level, 0);
        q_valid = 1'b1;
        q_in = 2'b10;
        send(5, 6, 5, 6, 0);
        q_valid = 1'b0;
        check("uf_push_stored", q_level, 1);
        send(10, 20, -10, -20, 0);
        check("uf_tag_used", q_level, 0);

        // Most negative input through a negating quadrant
        push_tag(2'b10);
        if (SAT_EN) send(-8388608, 0, 8388607, 0, 1);
        else        send(-8388608, 0, -8388608, 0, 0);
        tick();
        check("err_sticky", err_underflow, 1);

        // clr mid-stream with pending output
        for (int i = 0; i < 5; i++) push_tag(2'b00);
        o_ready = 1'b0;
        send(11, 12, 11, 12, 0);
        check("clr_pre_valid", o_valid, 1);
        check("clr_pre_level", q_level, 4);
        exp_q.delete();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_mid_level", q_level, 0);
        check("clr_mid_valid", o_valid, 0);
        check("clr_mid_err", err_underflow, 0);

        // Asynchronous reset mid-stream
        push_tag(2'b01);
        push_tag(2'b01);
        send(100, 200, -200, 100, 0);
        check("rstm_pre_valid", o_valid, 1);
        exp_q.delete();
        aresetn = 1'b0;
        #2;
        check("rstm_valid", o_valid, 0);
        check("rstm_cos", cos, 0);
        check("rstm_sin", sin, 0);
        check("rstm_level", q_level, 0);
        @(negedge clk);
        aresetn = 1'b1;
        o_ready = 1'b1;
        tick();
        check("rstm_qready", q_ready, 1);
        tick();
        check("final_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
